// File: rtl/hit_cnt_readout_ctrl_pkg.sv
// Shared types and constants for the counter-bank readout sequencer.
// Holds the FSM encoding, frame layout indices and the snapshot-to-word mapping.
package hit_cnt_readout_ctrl_pkg;

    localparam int unsigned FRAME_WORDS  = 14;
    localparam int unsigned IDX_W        = 4;
    localparam int unsigned DATA_W       = 16;
    localparam logic [7:0]  HDR_BYTE_DEF = 8'hEB;

    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(FRAME_WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_CSUM_SRC = IDX_W'(FRAME_WORDS - 2);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STROBE  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_SEND    = 3'd4
    } state_t;

    typedef struct packed {
        logic [31:0] hit_monit_cnt_0;
        logic [31:0] hit_monit_cnt_1;
        logic [15:0] busy_monit_cnt;
        logic [15:0] hit_start_cnt;
        logic [15:0] logic_match_cnt;
        logic [15:0] eff_trg_cnt;
        logic [15:0] coincid_trg_cnt;
        logic [15:0] ext_trg_cnt;
        logic [7:0]  hit_monit_sel;
        logic [7:0]  hit_monit_err_cnt;
        logic [7:0]  busy_monit_err_cnt;
        logic [7:0]  trg_delay_timer;
    } snap_t;

    // Payload word for a given index; the checksum word is built from the running XOR instead.
    function automatic logic [DATA_W-1:0] frame_word(input snap_t s, input logic [7:0] hdr,
                                                     input logic [7:0] seq,
                                                     input logic [IDX_W-1:0] idx);
        logic [DATA_W-1:0] w;
        w = '0;
        case (idx)
            4'd0:    w = {hdr, seq};
            4'd1:    w = s.hit_monit_cnt_0[31:16];
            4'd2:    w = s.hit_monit_cnt_0[15:0];
            4'd3:    w = s.hit_monit_cnt_1[31:16];
            4'd4:    w = s.hit_monit_cnt_1[15:0];
            4'd5:    w = s.busy_monit_cnt;
            4'd6:    w = s.hit_start_cnt;
            4'd7:    w = s.logic_match_cnt;
            4'd8:    w = s.eff_trg_cnt;
            4'd9:    w = s.coincid_trg_cnt;
            4'd10:   w = s.ext_trg_cnt;
            4'd11:   w = {s.hit_monit_sel, s.hit_monit_err_cnt};
            4'd12:   w = {s.busy_monit_err_cnt, s.trg_delay_timer};
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/readout_period_timer.sv
// Free-running auto-readout period counter; tick marks the last cycle of each period.
// Held at zero while disabled; PERIOD_CYC of 0 never ticks.
module readout_period_timer #(
    parameter int unsigned PERIOD_CYC = 50_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tick_c
);

    localparam int unsigned     CNT_W = 32;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(PERIOD_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_run;

    assign w_run    = i_en && (PERIOD_CYC != 0);
    assign o_tick_c = w_run && (r_cnt == TERM);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!w_run || o_tick_c) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hit_cnt_readout_ctrl.sv
// Counter-bank readout sequencer: strobe bank, wait for settle, snapshot, stream 14-word frame.
// One frame in flight, one request queued, further requests counted as overruns.
module hit_cnt_readout_ctrl
    import hit_cnt_readout_ctrl_pkg::*;
#(
    parameter int unsigned PERIOD_CYC = 50_000_000,
    parameter int unsigned LATCH_WAIT = 4,
    parameter logic [7:0]  HDR_BYTE   = HDR_BYTE_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        en_in,
    input  logic        req_in,
    input  logic [31:0] hit_monit_cnt_0_in,
    input  logic [31:0] hit_monit_cnt_1_in,
    input  logic [15:0] busy_monit_cnt_in,
    input  logic [15:0] hit_start_cnt_in,
    input  logic [15:0] logic_match_cnt_in,
    input  logic [15:0] eff_trg_cnt_in,
    input  logic [15:0] coincid_trg_cnt_in,
    input  logic [15:0] ext_trg_cnt_in,
    input  logic [7:0]  hit_monit_sel_in,
    input  logic [7:0]  hit_monit_err_cnt_in,
    input  logic [7:0]  busy_monit_err_cnt_in,
    input  logic [7:0]  trg_delay_timer_in,
    output logic        rd_out,
    output logic [15:0] frm_data_out,
    output logic        frm_valid_out,
    input  logic        frm_ready_in,
    output logic        frm_last_out,
    output logic        busy_out,
    output logic [7:0]  ovr_cnt_out
);

    localparam int unsigned WAIT_W = (LATCH_WAIT > 1) ? $clog2(LATCH_WAIT) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [7:0]          r_seq;
    logic [7:0]          r_ovr;
    logic                r_pending;
    snap_t               r_snap;
    snap_t               w_snap_in;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_xor;
    logic                r_rd;
    logic                r_valid;
    logic                r_last;
    logic                r_busy;

    logic w_tick;
    logic w_trig;
    logic w_capture;
    logic w_xfer;
    logic w_done;
    logic w_clr_pending;

    readout_period_timer #(
        .PERIOD_CYC (PERIOD_CYC)
    ) u_timer (
        .i_clk    (clk_in),
        .i_rst_n  (rst_in),
        .i_en     (en_in),
        .o_tick_c (w_tick)
    );

    assign w_trig = en_in && (w_tick || req_in);

    always_comb begin
        w_snap_in                    = '0;
        w_snap_in.hit_monit_cnt_0    = hit_monit_cnt_0_in;
        w_snap_in.hit_monit_cnt_1    = hit_monit_cnt_1_in;
        w_snap_in.busy_monit_cnt     = busy_monit_cnt_in;
        w_snap_in.hit_start_cnt      = hit_start_cnt_in;
        w_snap_in.logic_match_cnt    = logic_match_cnt_in;
        w_snap_in.eff_trg_cnt        = eff_trg_cnt_in;
        w_snap_in.coincid_trg_cnt    = coincid_trg_cnt_in;
        w_snap_in.ext_trg_cnt        = ext_trg_cnt_in;
        w_snap_in.hit_monit_sel      = hit_monit_sel_in;
        w_snap_in.hit_monit_err_cnt  = hit_monit_err_cnt_in;
        w_snap_in.busy_monit_err_cnt = busy_monit_err_cnt_in;
        w_snap_in.trg_delay_timer    = trg_delay_timer_in;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_capture     = 1'b0;
        w_done        = 1'b0;
        w_clr_pending = 1'b0;
        w_xfer        = r_valid && frm_ready_in;
        case (r_state)
            ST_IDLE: begin
                if (w_trig || r_pending) begin
                    w_clr_pending = 1'b1;
                    w_state_nxt   = ST_STROBE;
                end
            end
            ST_STROBE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (r_wait_cnt == WAIT_W'(LATCH_WAIT - 1)) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (w_xfer && (r_idx == IDX_LAST)) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_wait_cnt <= '0;
            r_idx      <= '0;
            r_seq      <= '0;
            r_ovr      <= '0;
            r_pending  <= 1'b0;
            r_snap     <= '0;
            r_data     <= '0;
            r_xor      <= '0;
            r_rd       <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rd       <= (w_state_nxt == ST_STROBE);
            r_valid    <= (w_state_nxt == ST_SEND);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + WAIT_W'(1) : '0;

            // One queued request; anything beyond that is an overrun.
            if (w_clr_pending) begin
                r_pending <= 1'b0;
            end else if (w_trig && r_busy) begin
                if (!r_pending) begin
                    r_pending <= 1'b1;
                end else if (r_ovr != 8'hFF) begin
                    r_ovr <= r_ovr + 8'd1;
                end
            end

            if (w_capture) begin
                r_snap <= w_snap_in;
                r_idx  <= '0;
                r_xor  <= '0;
                r_data <= {HDR_BYTE, r_seq};
                r_last <= 1'b0;
            end else if (w_xfer) begin
                r_xor <= r_xor ^ r_data;
                r_idx <= r_idx + IDX_W'(1);
                if (w_done) begin
                    r_seq  <= r_seq + 8'd1;
                    r_data <= '0;
                    r_last <= 1'b0;
                end else if (r_idx == IDX_CSUM_SRC) begin
                    r_data <= r_xor ^ r_data;
                    r_last <= 1'b1;
                end else begin
                    r_data <= frame_word(r_snap, HDR_BYTE, r_seq, r_idx + IDX_W'(1));
                end
            end
        end
    end

    assign rd_out        = r_rd;
    assign frm_data_out  = r_data;
    assign frm_valid_out = r_valid;
    assign frm_last_out  = r_last;
    assign busy_out      = r_busy;
    assign ovr_cnt_out   = r_ovr;

endmodule

// File: tb/tb_hit_cnt_readout_ctrl.sv
// Bench for hit_cnt_readout_ctrl: random counter values and ready patterns against a frame model.
// A second instance with a 100-cycle period exercises the auto-readout timer.
`timescale 1ns/1ps
module tb_hit_cnt_readout_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, req, ready;
    logic        en_t, req_t, ready_t;
    logic [31:0] c0, c1;
    logic [15:0] busy_m, hstart, lmatch, efft, coin, ext;
    logic [7:0]  sel, herr, berr, tdly;

    logic        rd, valid, last, busy;
    logic [15:0] data;
    logic [7:0]  ovr;
    logic        rd_t, valid_t, last_t, busy_t;
    logic [15:0] data_t;
    logic [7:0]  ovr_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rd_cnt = 0;
    logic [7:0] m_seq;
    int m_ovr;

    int rd_t_times[$];
    logic [15:0] t_w0[$];
    int t_idx = 0;

    hit_cnt_readout_ctrl #(.PERIOD_CYC(0), .LATCH_WAIT(4), .HDR_BYTE(8'hEB)) dut (
        .clk_in(clk), .rst_in(rst_n), .en_in(en), .req_in(req),
        .hit_monit_cnt_0_in(c0), .hit_monit_cnt_1_in(c1), .busy_monit_cnt_in(busy_m),
        .hit_start_cnt_in(hstart), .logic_match_cnt_in(lmatch), .eff_trg_cnt_in(efft),
        .coincid_trg_cnt_in(coin), .ext_trg_cnt_in(ext), .hit_monit_sel_in(sel),
        .hit_monit_err_cnt_in(herr), .busy_monit_err_cnt_in(berr), .trg_delay_timer_in(tdly),
        .rd_out(rd), .frm_data_out(data), .frm_valid_out(valid), .frm_ready_in(ready),
        .frm_last_out(last), .busy_out(busy), .ovr_cnt_out(ovr));

    hit_cnt_readout_ctrl #(.PERIOD_CYC(100), .LATCH_WAIT(4), .HDR_BYTE(8'hEB)) dut_t (
        .clk_in(clk), .rst_in(rst_n), .en_in(en_t), .req_in(req_t),
        .hit_monit_cnt_0_in(c0), .hit_monit_cnt_1_in(c1), .busy_monit_cnt_in(busy_m),
        .hit_start_cnt_in(hstart), .logic_match_cnt_in(lmatch), .eff_trg_cnt_in(efft),
        .coincid_trg_cnt_in(coin), .ext_trg_cnt_in(ext), .hit_monit_sel_in(sel),
        .hit_monit_err_cnt_in(herr), .busy_monit_err_cnt_in(berr), .trg_delay_timer_in(tdly),
        .rd_out(rd_t), .frm_data_out(data_t), .frm_valid_out(valid_t), .frm_ready_in(ready_t),
        .frm_last_out(last_t), .busy_out(busy_t), .ovr_cnt_out(ovr_t));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd === 1'b1) rd_cnt++;
        if (rd_t === 1'b1) rd_t_times.push_back(cyc);
        if (valid_t === 1'b1 && ready_t === 1'b1) begin
            if (t_idx == 0) t_w0.push_back(data_t);
            t_idx = (last_t === 1'b1) ? 0 : t_idx + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Frame model straight from the word map: header, counters, XOR of words 0..12.
    function automatic void model_frame(input logic [7:0] s, output logic [15:0] e [14]);
        e[0] = {8'hEB, s};       e[1] = c0[31:16];  e[2] = c0[15:0];
        e[3] = c1[31:16];        e[4] = c1[15:0];   e[5] = busy_m;
        e[6] = hstart;           e[7] = lmatch;     e[8] = efft;
        e[9] = coin;             e[10] = ext;       e[11] = {sel, herr};
        e[12] = {berr, tdly};    e[13] = 16'h0000;
        for (int k = 0; k < 13; k++) e[13] = e[13] ^ e[k];
    endfunction

    task automatic rand_inputs();
        c0 = $urandom; c1 = $urandom;
        busy_m = 16'($urandom); hstart = 16'($urandom); lmatch = 16'($urandom);
        efft = 16'($urandom); coin = 16'($urandom); ext = 16'($urandom);
        sel = 8'($urandom); herr = 8'($urandom); berr = 8'($urandom); tdly = 8'($urandom);
    endtask

    task automatic pulse_req();
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
    endtask

    // Gathers one frame; mode 0 ready always, 1 toggling, 2 random.
    task automatic collect_frame(input int mode, output logic [15:0] w [14], output logic [13:0] lasts,
                                 output int first_c, output int last_c, output bit to, output bit unstable);
        int n;
        int waited;
        bit stalled;
        logic [15:0] held;
        n = 0; waited = 0; stalled = 0; held = '0;
        to = 0; unstable = 0; lasts = '0; first_c = 0; last_c = 0;
        for (int k = 0; k < 14; k++) w[k] = '0;
        while (n < 14 && !to) begin
            @(negedge clk);
            if (stalled && (valid !== 1'b1 || data !== held)) unstable = 1;
            case (mode)
                0:       ready = 1'b1;
                1:       ready = cyc[0];
                default: ready = 1'($urandom_range(0, 1));
            endcase
            if (valid === 1'b1 && ready) begin
                w[n] = data; lasts[n] = last;
                if (n == 0) first_c = cyc;
                last_c = cyc;
                n++; stalled = 0;
            end else if (valid === 1'b1) begin
                stalled = 1; held = data;
            end else begin
                stalled = 0;
            end
            waited++;
            if (waited > 400) to = 1;
        end
        @(negedge clk); ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; req = 1'b0; ready = 1'b0;
        en_t = 1'b0; req_t = 1'b0; ready_t = 1'b1;
        rand_inputs();
        repeat (3) @(negedge clk);
        total++;
        if ({rd, valid, last, busy} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl: rd/valid/last/busy=%b exp 0000", {rd, valid, last, busy});
        end
        total++;
        if (data !== 16'h0000 || ovr !== 8'h00) begin
            bad++; $display("FAIL reset_data: data=%h ovr=%h exp 0000/00", data, ovr);
        end
        total++;
        if ({rd_t, valid_t, busy_t} !== 3'b000 || ovr_t !== 8'h00) begin
            bad++; $display("FAIL reset_timer_inst: rd/valid/busy=%b ovr=%h exp 000/00", {rd_t, valid_t, busy_t}, ovr_t);
        end
        rst_n = 1'b1;
        m_seq = 8'h00; m_ovr = 0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || rd_cnt !== 0) begin
            bad++; $display("FAIL reset_idle: busy=%b rd_pulses=%0d exp 0/0", busy, rd_cnt);
        end
    endtask

    task automatic test_single_req();
        logic [15:0] w [14];
        logic [15:0] e [14];
        logic [13:0] lasts;
        int fc, lc, rd0, nm;
        bit to, unst;
        en = 1'b1;
        rand_inputs();
        c0 = 32'h12345678; ext = 16'h00AA;
        model_frame(m_seq, e);
        rd0 = rd_cnt;
        pulse_req();
        collect_frame(0, w, lasts, fc, lc, to, unst);
        total++;
        if (to) begin bad++; $display("FAIL single_timeout: frame incomplete exp 14 words"); end
        total++;
        if (w[0] !== 16'hEB00) begin bad++; $display("FAIL single_w0: got %h exp eb00", w[0]); end
        total++;
        if (w[1] !== 16'h1234 || w[2] !== 16'h5678) begin
            bad++; $display("FAIL single_w1w2: got %h %h exp 1234 5678", w[1], w[2]);
        end
        total++;
        if (w[10] !== 16'h00AA) begin bad++; $display("FAIL single_w10: got %h exp 00aa", w[10]); end
        total++;
        if (w[13] !== e[13]) begin bad++; $display("FAIL single_csum: got %h exp %h", w[13], e[13]); end
        nm = 0;
        for (int k = 0; k < 14; k++) if (w[k] !== e[k]) nm++;
        total++;
        if (nm != 0) begin bad++; $display("FAIL single_words: %0d words differ exp 0", nm); end
        total++;
        if (lasts !== 14'h2000) begin bad++; $display("FAIL single_last: flags %b exp %b", lasts, 14'h2000); end
        total++;
        if (lc - fc != 13) begin bad++; $display("FAIL single_consec: span %0d exp 13", lc - fc); end
        total++;
        if (rd_cnt - rd0 != 1) begin bad++; $display("FAIL single_rd: %0d strobe cycles exp 1", rd_cnt - rd0); end
        total++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            bad++; $display("FAIL single_idle: busy=%b valid=%b exp 0/0", busy, valid);
        end
        m_seq++;
    endtask

    task automatic test_backpressure();
        logic [15:0] w [14];
        logic [15:0] e [14];
        logic [13:0] lasts;
        int fc, lc, nm;
        bit to, unst;
        rand_inputs();
        model_frame(m_seq, e);
        pulse_req();
        collect_frame(1, w, lasts, fc, lc, to, unst);
        total++;
        if (to || unst) begin bad++; $display("FAIL bp_stable: timeout=%0d unstable=%0d exp 0/0", to, unst); end
        nm = 0;
        for (int k = 0; k < 14; k++) if (w[k] !== e[k]) nm++;
        total++;
        if (nm != 0) begin bad++; $display("FAIL bp_words: %0d differ, w0 got %h exp %h", nm, w[0], e[0]); end
        total++;
        if (lasts !== 14'h2000) begin bad++; $display("FAIL bp_last: flags %b exp %b", lasts, 14'h2000); end
        m_seq++;
    endtask

    task automatic test_random_frames();
        logic [15:0] w [14];
        logic [15:0] e [14];
        logic [13:0] lasts;
        int fc, lc, nm;
        bit to, unst;
        for (int f = 0; f < 6; f++) begin
            rand_inputs();
            model_frame(m_seq, e);
            pulse_req();
            repeat (10) @(negedge clk);
            rand_inputs();   // must not leak into an already-captured frame
            collect_frame(2, w, lasts, fc, lc, to, unst);
            nm = 0;
            for (int k = 0; k < 14; k++) if (w[k] !== e[k]) nm++;
            total++;
            if (to || unst || nm != 0 || lasts !== 14'h2000) begin
                bad++;
                $display("FAIL rand_frame%0d: to=%0d unst=%0d diff=%0d last=%b exp 0/0/0/%b", f, to, unst, nm, lasts, 14'h2000);
            end
            m_seq++;
        end
    endtask

    task automatic test_queue_overflow();
        logic [15:0] w [14];
        logic [15:0] e [14];
        logic [13:0] lasts;
        int fc, lc, fc2, lc2, nm, rd0;
        bit to, unst;
        rand_inputs();
        rd0 = rd_cnt;
        pulse_req(); pulse_req(); pulse_req();
        m_ovr++;
        collect_frame(0, w, lasts, fc, lc, to, unst);
        model_frame(m_seq, e);
        nm = 0;
        for (int k = 0; k < 14; k++) if (w[k] !== e[k]) nm++;
        total++;
        if (to || nm != 0) begin bad++; $display("FAIL queue_frame1: to=%0d diff=%0d exp 0/0", to, nm); end
        m_seq++;
        collect_frame(0, w, lasts, fc2, lc2, to, unst);
        model_frame(m_seq, e);
        nm = 0;
        for (int k = 0; k < 14; k++) if (w[k] !== e[k]) nm++;
        total++;
        if (to || nm != 0) begin bad++; $display("FAIL queue_frame2: to=%0d diff=%0d exp 0/0", to, nm); end
        m_seq++;
        total++;
        if (fc2 - lc > 10) begin bad++; $display("FAIL queue_gap: %0d cycles exp <=10", fc2 - lc); end
        total++;
        if (ovr !== 8'(m_ovr)) begin bad++; $display("FAIL queue_ovr: got %0d exp %0d", ovr, m_ovr); end
        repeat (40) @(negedge clk);
        total++;
        if (busy !== 1'b0 || rd_cnt - rd0 != 2) begin
            bad++; $display("FAIL queue_no_third: busy=%b strobes=%0d exp 0/2", busy, rd_cnt - rd0);
        end
    endtask

    task automatic test_ovr_saturate();
        logic [15:0] w [14];
        logic [15:0] e [14];
        logic [13:0] lasts;
        int fc, lc, nm;
        bit to, unst;
        ready = 1'b0;
        rand_inputs();
        pulse_req();
        for (int i = 0; i < 11; i++) pulse_req();
        m_ovr += 10;
        total++;
        if (ovr !== 8'(m_ovr)) begin bad++; $display("FAIL ovr_count: got %0d exp %0d", ovr, m_ovr); end
        for (int i = 0; i < 300; i++) pulse_req();
        m_ovr = 255;
        total++;
        if (ovr !== 8'hFF) begin bad++; $display("FAIL ovr_saturate: got %0d exp 255", ovr); end
        for (int f = 0; f < 2; f++) begin
            model_frame(m_seq, e);
            collect_frame(0, w, lasts, fc, lc, to, unst);
            nm = 0;
            for (int k = 0; k < 14; k++) if (w[k] !== e[k]) nm++;
            total++;
            if (to || nm != 0) begin bad++; $display("FAIL ovr_drain%0d: to=%0d diff=%0d exp 0/0", f, to, nm); end
            m_seq++;
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] w [14];
        logic [15:0] e [14];
        logic [13:0] lasts;
        int fc, lc, n, waited, nm;
        bit to, unst;
        rand_inputs();
        pulse_req();
        n = 0; waited = 0;
        while (waited < 200) begin
            @(negedge clk);
            waited++;
            if (valid === 1'b1 && n == 6) break;
            ready = 1'b1;
            if (valid === 1'b1) n++;
        end
        total++;
        if (n != 6) begin bad++; $display("FAIL rstmid_reach: reached word %0d exp 6", n); end
        rst_n = 1'b0; ready = 1'b0;
        @(negedge clk);
        total++;
        if (valid !== 1'b0 || busy !== 1'b0 || ovr !== 8'h00 || data !== 16'h0000) begin
            bad++; $display("FAIL rstmid_clear: valid=%b busy=%b ovr=%h data=%h exp 0/0/00/0000", valid, busy, ovr, data);
        end
        rst_n = 1'b1;
        m_seq = 8'h00; m_ovr = 0;
        rand_inputs();
        model_frame(m_seq, e);
        pulse_req();
        collect_frame(0, w, lasts, fc, lc, to, unst);
        total++;
        if (w[0] !== 16'hEB00) begin bad++; $display("FAIL rstmid_w0: got %h exp eb00", w[0]); end
        nm = 0;
        for (int k = 0; k < 14; k++) if (w[k] !== e[k]) nm++;
        total++;
        if (to || nm != 0 || lasts !== 14'h2000) begin
            bad++; $display("FAIL rstmid_frame: to=%0d diff=%0d last=%b exp 0/0/%b", to, nm, lasts, 14'h2000);
        end
        m_seq++;
    endtask

    task automatic test_timer();
        int e0, nsp, nw, sz;
        en = 1'b0;
        rd_t_times.delete(); t_w0.delete();
        @(negedge clk);
        en_t = 1'b1; e0 = cyc;
        repeat (257 * 100 + 40) @(negedge clk);
        en_t = 1'b0;
        repeat (40) @(negedge clk);
        total++;
        if (rd_t_times.size() != 257) begin bad++; $display("FAIL timer_count: %0d strobes exp 257", rd_t_times.size()); end
        total++;
        if (rd_t_times.size() == 0 || rd_t_times[0] - e0 != 100) begin
            bad++; $display("FAIL timer_first: offset %0d exp 100", (rd_t_times.size() == 0) ? -1 : rd_t_times[0] - e0);
        end
        nsp = 0;
        for (int i = 1; i < rd_t_times.size(); i++) if (rd_t_times[i] - rd_t_times[i-1] != 100) nsp++;
        total++;
        if (nsp != 0) begin bad++; $display("FAIL timer_period: %0d gaps differ exp 0", nsp); end
        nw = 0;
        for (int i = 0; i < t_w0.size(); i++) if (t_w0[i] !== {8'hEB, 8'(i)}) nw++;
        total++;
        if (t_w0.size() != 257 || nw != 0) begin
            bad++; $display("FAIL timer_seq: frames=%0d bad_hdr=%0d exp 257/0", t_w0.size(), nw);
        end
        total++;
        if (t_w0.size() < 257 || t_w0[256] !== 16'hEB00) begin
            bad++; $display("FAIL timer_wrap: last hdr %h exp eb00", (t_w0.size() < 257) ? 16'h0 : t_w0[256]);
        end
        sz = rd_t_times.size();
        repeat (250) @(negedge clk);
        total++;
        if (rd_t_times.size() != sz) begin bad++; $display("FAIL timer_disabled: %0d new strobes exp 0", rd_t_times.size() - sz); end
        en_t = 1'b1; e0 = cyc;
        repeat (120) @(negedge clk);
        en_t = 1'b0;
        total++;
        if (rd_t_times.size() != sz + 1 || rd_t_times[rd_t_times.size()-1] - e0 != 100) begin
            bad++; $display("FAIL timer_restart: strobes=%0d offset=%0d exp 1/100", rd_t_times.size() - sz,
                            rd_t_times[rd_t_times.size()-1] - e0);
        end
        repeat (40) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_req();
        test_backpressure();
        test_random_frames();
        test_queue_overflow();
        test_ovr_saturate();
        test_reset_midframe();
        test_timer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
